otter_fetch_ctrl: RTL

OTTER_FETCH_CTRL -- requirements
Module: otter_fetch_ctrl

---
 rtl/otter_fetch_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/otter_fetch_ctrl.sv
// OTTER instruction fetch controller: keeps at most one memory request in flight,
// holds fetched words for decode, and redirects on taken branches and jumps.
module otter_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_is_branch,
    input  logic        i_br_taken,
    input  logic        i_is_jump,
    input  logic [31:0] i_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_valid,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_instr,
    input  logic        i_if_ready,
    output logic        o_misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        misal_q, misal_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;

    logic redirect;
    logic aligned;
    logic redir_ok;

    assign redirect = (i_is_branch & i_br_taken) | i_is_jump;
    assign aligned  = (i_target[1:0] == 2'b00);
    assign redir_ok = redirect & aligned;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            misal_q    <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            misal_q    <= misal_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        misal_d    = redirect & ~aligned;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redir_ok) pc_d = i_target;
            end
            REQ: begin
                if (redir_ok) pc_d = i_target;
                if (i_imem_gnt) begin
                    state_d = WAIT;
                    // Grant belongs to the old address, so its data must be dropped.
                    if (redir_ok) drop_d = 1'b1;
                end
            end
            WAIT: begin
                if (redir_ok) begin
                    pc_d = i_target;
                    if (i_imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (i_imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        if_pc_d    = pc_q;
                        if_instr_d = i_imem_rdata;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redir_ok) begin
                    pc_d    = i_target;
                    state_d = REQ;
                end else if (i_if_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_imem_req   = (state_q == REQ);
    assign o_imem_addr  = (state_q == REQ) ? pc_q : '0;
    assign o_if_valid   = (state_q == HOLD);
    assign o_if_pc      = if_pc_q;
    assign o_if_instr   = if_instr_q;
    assign o_misaligned = misal_q;

endmodule
